// File: rtl/alu_seq_if.sv
// alu_seq_if: operation bus between the issuing stage and alu_seq.
//
// Handshake: the master holds start high with aluop/a/b stable. The operation
// is accepted on the first rising clk edge where start=1 and the ALU is idle;
// busy is high from the cycle after that edge until done. done is a one-cycle
// pulse, and result/result_hi/cout/zero (and ovf) are valid from that pulse
// until the next pulse. start is ignored while busy or during the done cycle.
//
// Signals:
//   start, aluop[2:0], a, b            master -> slave
//   busy, done, result, result_hi,
//   cout, zero                         slave -> master
//   ovf (only with ALU_SEQ_OVF_EN)     slave -> master
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       aluop;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             cout;
  logic             zero;
`ifdef ALU_SEQ_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, aluop, a, b,
    input  busy, done, result, result_hi, cout, zero
`ifdef ALU_SEQ_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, aluop, a, b,
    output busy, done, result, result_hi, cout, zero
`ifdef ALU_SEQ_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit sequential ALU with registered operands, start/done
// handshake and a shift-add unsigned multiplier (WIDTH iterations).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        alu_seq_if.slave (start, aluop, a, b, busy, done, result,
//              result_hi, cout, zero, and ovf when enabled)
//   dbg_state  current FSM state (IDLE=0, EXEC=1, MULT=2, DONE=3)
//
// aluop: 000 add, 001 xor, 010 sub, 011 mult, 100 slt, 101 nor, 110 and, 111 or
// Optional feature macro: ALU_SEQ_OVF_EN adds the signed-overflow output ovf.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  alu_seq_if.slave     bus,
  output logic [1:0]   dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MULT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_OR  = 3'b111;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic               r_cout;
  logic               r_zero;

  logic               w_accept;
  logic               w_mult_last;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic               w_slt;
  logic [WIDTH:0]     w_mac;
  logic [WIDTH-1:0]   w_exec_res;
  logic               w_exec_cout;

  assign w_accept    = (r_state == S_IDLE) && bus.start;
  // WIDTH shift-add steps run at counts 0..WIDTH-1; the extra count loads outputs.
  assign w_mult_last = (r_cnt == CNT_W'(WIDTH));

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next_state = (bus.aluop == OP_MUL) ? S_MULT : S_EXEC;
      S_EXEC: w_next_state = S_DONE;
      S_MULT: if (w_mult_last) w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------- single-cycle datapath ----------------
  assign w_add = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub = {1'b0, r_a} + {1'b0, ~r_b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_slt = $signed(r_a) < $signed(r_b);

  always_comb begin
    w_exec_res  = '0;
    w_exec_cout = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_exec_res  = w_add[WIDTH-1:0];
        w_exec_cout = w_add[WIDTH];
      end
      OP_SUB: begin
        w_exec_res  = w_sub[WIDTH-1:0];
        w_exec_cout = w_sub[WIDTH];
      end
      OP_XOR: w_exec_res = r_a ^ r_b;
      OP_SLT: w_exec_res = {{(WIDTH-1){1'b0}}, w_slt};
      OP_NOR: w_exec_res = ~(r_a | r_b);
      OP_AND: w_exec_res = r_a & r_b;
      OP_OR:  w_exec_res = r_a | r_b;
      default: w_exec_res = '0; // mult never goes through EXEC
    endcase
  end

  // Accumulator starts as {0, b}: the low half doubles as the multiplier, so
  // acc[0] is the current multiplier bit and the product shifts in from the top.
  assign w_mac = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_cout      <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= bus.a;
        r_b   <= bus.b;
        r_op  <= bus.aluop;
        r_acc <= {{WIDTH{1'b0}}, bus.b};
        r_cnt <= '0;
      end
      if (r_state == S_EXEC) begin
        r_result    <= w_exec_res;
        r_result_hi <= '0;
        r_cout      <= w_exec_cout;
        r_zero      <= (w_exec_res == '0);
      end
      if (r_state == S_MULT) begin
        if (w_mult_last) begin
          r_result    <= r_acc[WIDTH-1:0];
          r_result_hi <= r_acc[2*WIDTH-1:WIDTH];
          r_cout      <= 1'b0;
          r_zero      <= (r_acc[WIDTH-1:0] == '0);
        end else begin
          r_acc <= {w_mac, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef ALU_SEQ_OVF_EN
  logic r_ovf;
  logic w_add_ovf;
  logic w_sub_ovf;
  logic w_exec_ovf;

  // Sub overflow uses the inverted b operand, matching the adder input.
  assign w_add_ovf  = (r_a[WIDTH-1] == r_b[WIDTH-1])  && (w_add[WIDTH-1] != r_a[WIDTH-1]);
  assign w_sub_ovf  = (r_a[WIDTH-1] == ~r_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_a[WIDTH-1]);
  assign w_exec_ovf = (r_op == OP_ADD) ? w_add_ovf :
                      (r_op == OP_SUB) ? w_sub_ovf : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_ovf <= w_exec_ovf;
    end else if ((r_state == S_MULT) && w_mult_last) begin
      r_ovf <= |r_acc[2*WIDTH-1:WIDTH];
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.busy      = (r_state == S_EXEC) || (r_state == S_MULT);
  assign bus.done      = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.result_hi = r_result_hi;
  assign bus.cout      = r_cout;
  assign bus.zero      = r_zero;
  assign dbg_state     = r_state;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq at WIDTH=8.
module tb_alu_seq;
  localparam int W  = 8;
  localparam int EW = 2*W + 3; // {result_hi, result, cout, zero, ovf}
`ifdef ALU_SEQ_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus();
  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_exp = '0;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         cout;
    logic         zero;
    logic         ovf;
    logic         poke;
  } vec_t;
  vec_t vecs[12];

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic [W-1:0] hi, input logic [W-1:0] lo,
                                         input logic c, input logic z, input logic o);
    return {hi, lo, c, z, o & OVF_ON};
  endfunction

  function automatic logic [EW-1:0] act_word();
    logic o;
`ifdef ALU_SEQ_OVF_EN
    o = bus.ovf;
`else
    o = 1'b0;
`endif
    return {bus.result_hi, bus.result, bus.cout, bus.zero, o};
  endfunction

  // Reference model written from arithmetic, not from the adder structure.
  function automatic logic [EW-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    int sa, sb, r, smax, smin;
    logic [2*W-1:0] p;
    logic [W-1:0] lo, hi;
    logic c, o;
    sa = int'($signed(a));
    sb = int'($signed(b));
    smax = (1 << (W-1)) - 1;
    smin = -(1 << (W-1));
    lo = '0; hi = '0; c = 1'b0; o = 1'b0; r = 0; p = '0;
    case (op)
      3'b000: begin r = int'(a) + int'(b); lo = r[W-1:0]; c = (r >= (1 << W));
                    o = (sa + sb > smax) || (sa + sb < smin); end
      3'b001: lo = a ^ b;
      3'b010: begin r = int'(a) - int'(b); lo = r[W-1:0]; c = (a >= b);
                    o = (sa - sb > smax) || (sa - sb < smin); end
      3'b011: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; lo = p[W-1:0]; hi = p[2*W-1:W];
                    o = (hi != 0); end
      3'b100: lo = (sa < sb) ? W'(1) : W'(0);
      3'b101: lo = ~(a | b);
      3'b110: lo = a & b;
      default: lo = a | b;
    endcase
    return pack(hi, lo, c, (lo == 0), o);
  endfunction

  // Wait (sampling on negedges) until done; returns cycles waited, -1 on timeout.
  task automatic wait_done(output int cyc, input bit poke);
    cyc = 0;
    while (!bus.done && cyc < 200) begin
      if (poke && cyc == 3) begin
        bus.start = 1'b1; bus.aluop = 3'b000; bus.a = '0; bus.b = '0;
      end
      if (poke && cyc == 4) bus.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (!bus.done) cyc = -1;
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [EW-1:0] e, input bit poke);
    int cyc;
    int exp_cyc;
    exp_cyc = (op == 3'b011) ? W + 1 : 1;
    @(negedge clk);
    bus.start = 1'b1; bus.aluop = op; bus.a = a; bus.b = b;
    exp_q.push_back(e);
    @(negedge clk);
    // Scramble inputs: the DUT must have latched the operands already.
    bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom);
    bus.aluop = 3'($urandom_range(0, 7));
    check("busy_after_start", bus.busy, 1'b1);
    check("outputs_hold", act_word(), last_exp);
    wait_done(cyc, poke);
    if (cyc < 0) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: op %0d got no done, expected one", op);
      void'(exp_q.pop_front());
    end else begin
      check("latency", cyc, exp_cyc);
      check("busy_at_done", bus.busy, 1'b0);
      check("result", act_word(), exp_q.pop_front());
      @(negedge clk);
      check("done_one_cycle", bus.done, 1'b0);
      check("result_held", act_word(), e);
    end
    last_exp = e;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    bit seen;
    logic [2:0] rop;
    logic [W-1:0] ra, rb;

    vecs[0]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{3'b010, 8'h05, 8'h07, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'b100, 8'h80, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'b100, 8'h01, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{3'b011, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{3'b101, 8'hF0, 8'h0F, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{3'b110, 8'hCC, 8'hAA, 8'h88, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b111, 8'hCC, 8'hAA, 8'hEE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b001, 8'hCC, 8'hAA, 8'h66, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{3'b010, 8'h80, 8'h01, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{3'b011, 8'h0D, 8'h0B, 8'h8F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

    bus.start = 1'b0; bus.aluop = '0; bus.a = '0; bus.b = '0;
    #1;
    check("reset_outputs", act_word(), '0);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table vectors
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b,
             pack(vecs[i].hi, vecs[i].res, vecs[i].cout, vecs[i].zero, vecs[i].ovf),
             vecs[i].poke);
    end

    // Random vectors against the model
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom_range(0, 255));
      rb  = W'($urandom_range(0, 255));
      run_op(rop, ra, rb, model(rop, ra, rb), 1'b0);
    end

    // Reset 3 cycles into a multiply: immediate abort, no done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.aluop = 3'b011; bus.a = 8'h12; bus.b = 8'h34;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_outputs", act_word(), '0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    rst = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("abort_no_done", seen, 1'b0);
    last_exp = '0;
    run_op(3'b000, 8'd3, 8'd4, pack(8'h00, 8'h07, 1'b0, 1'b0, 1'b0), 1'b0);

    // start held high: second op accepted after exactly one idle edge.
    @(negedge clk);
    bus.start = 1'b1; bus.aluop = 3'b000; bus.a = 8'd1; bus.b = 8'd2;
    exp_q.push_back(model(3'b000, 8'd1, 8'd2));
    exp_q.push_back(model(3'b000, 8'd1, 8'd2));
    @(negedge clk);
    wait_done(cyc, 1'b0);
    check("b2b_first_latency", cyc, 1);
    check("b2b_first_result", act_word(), exp_q.pop_front());
    @(negedge clk);
    check("b2b_idle_gap_busy", bus.busy, 1'b0);
    check("b2b_idle_gap_done", bus.done, 1'b0);
    @(negedge clk);
    check("b2b_second_busy", bus.busy, 1'b1);
    bus.start = 1'b0;
    wait_done(cyc, 1'b0);
    check("b2b_second_latency", cyc, 1);
    check("b2b_second_result", act_word(), exp_q.pop_front());

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised WIDTH-bit ALU that succeeds the 1-bit ALU slice and keeps the same 3-bit ALUOP encoding.
- Registered operands, start/done handshake, and a multi-cycle shift-add unsigned multiplier; the old slice tied MULT and SLT to 0.
- Single-cycle ops (add, xor, sub, slt, nor, and, or) complete one cycle after start.
- Sits between the register file and the writeback stage of the course datapath.

Parameters:
- WIDTH, 32, operand and result width in bits (legal values are 4 or more).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  launches an operation when high in IDLE.
- aluop  input  3  000 add, 001 xor, 010 sub, 011 mult, 100 slt, 101 nor, 110 and, 111 or.
- a  input  WIDTH  operand A, sampled on the accepting start edge.
- b  input  WIDTH  operand B, sampled on the accepting start edge.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; result is valid from this cycle on.
- result  output  WIDTH  low result word.
- result_hi  output  WIDTH  high product word for mult, 0 for all other ops.
- cout  output  1  carry out for add/sub, 0 for all other ops.
- zero  output  1  high when result equals 0 (result_hi is ignored).

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, cout and zero all 0; result and result_hi all 0; multiplier counter 0.
- States: IDLE, EXEC, MULT, DONE.
- IDLE + start=1: latch a, b and aluop; go to MULT if aluop=011, otherwise go to EXEC.
- EXEC: compute for one cycle, load the outputs, go to DONE.
- MULT: shift-add, one multiplier bit per cycle from the LSB. A 2*WIDTH accumulator iterates exactly WIDTH cycles, then goes to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE. A start in DONE is ignored; it is accepted only in IDLE.
- Latency from the start edge (cycle t) to the done pulse:
  - single-cycle ops: done at t+2;
  - mult: done at t+WIDTH+2.
- busy is high in EXEC and MULT. start while busy is ignored and the operands are not re-sampled.
- result, result_hi, cout and zero hold their values until the next done; they do not change mid-operation.
- add: {cout, result} = a + b, modulo 2^WIDTH, with carry out.
- sub: result = a + ~b + 1; cout=1 means no borrow (a >= b unsigned).
- slt: signed two's-complement compare; result = 1 if a < b, else 0, zero-extended.
- nor, and, or, xor: bitwise on WIDTH bits.
- mult: unsigned; {result_hi, result} = a * b (2*WIDTH bits); cout=0.
- Undefined aluop cannot occur: all 8 codes are defined.
- rst asserted mid-MULT or mid-EXEC: immediate return to IDLE with the reset values above; no done pulse for the aborted op.
- start held high continuously: a new op is accepted on each return to IDLE, i.e. back-to-back with one idle edge between ops.

Optional Feature:
- Macro: ALU_SEQ_OVF_EN.
- Defined:
  - adds output port ovf (1 bit, reset 0), updated together with done;
  - add/sub: ovf = signed two's-complement overflow (operand sign bits equal, result sign different; for sub the inverted b is used);
  - mult: ovf = 1 if result_hi is nonzero;
  - all other ops: ovf = 0.
- Not defined: the port does not exist and there is no overflow logic.

Test Plan:
- WIDTH=8, add a=8'hFF, b=8'h01 -> done at t+2; result=8'h00, cout=1, zero=1, result_hi=0.
- WIDTH=8, sub a=8'h05, b=8'h07 -> result=8'hFE, cout=0, zero=0; with ALU_SEQ_OVF_EN, ovf=0.
- WIDTH=8, slt a=8'h80 (-128), b=8'h01 -> result=8'h01. slt a=8'h01, b=8'h80 -> result=8'h00.
- WIDTH=8, mult a=8'hFF, b=8'hFF -> busy for 9 cycles, done at t+10; result_hi=8'hFE, result=8'h01. A start pulsed mid-operation is ignored.
- WIDTH=8, nor a=8'hF0, b=8'h0F -> result=8'h00, zero=1. and/or/xor with a=8'hCC, b=8'hAA -> 8'h88, 8'hEE, 8'h66.
- Start mult, assert rst 3 cycles in -> busy=0 and result=0 immediately, no done pulse. After release, add a=3, b=4 -> result=7 at t+2.
